// File: rtl/ama_riscv_ret_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_ret_tracker_if
// Description : Bundle of pipeline controls, entry payload, retirement view
//               and counter readout for ama_riscv_ret_tracker.
//               Optional macro: AMA_RISCV_RET_TRACKER_BP_EN (adds bp_hit).
// Revision    : 1.0 - initial release
// ============================================================================
interface ama_riscv_ret_tracker_if #(
   parameter int NSTAGES    = 3,
   parameter int ARCH_WIDTH = 32,
   parameter int CNT_W      = 32
);
   logic [NSTAGES-1:0]    stage_en;
   logic [NSTAGES-1:0]    stage_flush;
   logic [NSTAGES-1:0]    stage_bubble;
   logic                  in_valid;
   logic [31:0]           in_inst;
   logic [ARCH_WIDTH-1:0] in_pc;
   logic                  in_branch;
   logic [ARCH_WIDTH-1:0] in_dmem_addr;
   logic                  in_dmem_valid;
   logic [2:0]            in_dmem_size;
   logic                  in_br_taken;
`ifdef AMA_RISCV_RET_TRACKER_BP_EN
   logic                  bp_hit;
`endif
   logic                  inst_retired;
   logic                  cnt_clr;
   logic [2:0]            cnt_sel;

   logic [31:0]           ret_inst;
   logic [ARCH_WIDTH-1:0] ret_pc;
   logic                  ret_branch;
   logic                  ret_taken;
   logic [ARCH_WIDTH-1:0] ret_dmem_addr;
   logic [3:0]            ret_dmem_size;
   logic                  ret_bubble;
   logic                  ret_bp_hit;
   logic [CNT_W-1:0]      cnt_rdata;

   modport master (
      output stage_en, stage_flush, stage_bubble,
      output in_valid, in_inst, in_pc, in_branch,
      output in_dmem_addr, in_dmem_valid, in_dmem_size, in_br_taken,
`ifdef AMA_RISCV_RET_TRACKER_BP_EN
      output bp_hit,
`endif
      output inst_retired, cnt_clr, cnt_sel,
      input  ret_inst, ret_pc, ret_branch, ret_taken,
      input  ret_dmem_addr, ret_dmem_size, ret_bubble, ret_bp_hit,
      input  cnt_rdata
   );

   modport slave (
      input  stage_en, stage_flush, stage_bubble,
      input  in_valid, in_inst, in_pc, in_branch,
      input  in_dmem_addr, in_dmem_valid, in_dmem_size, in_br_taken,
`ifdef AMA_RISCV_RET_TRACKER_BP_EN
      input  bp_hit,
`endif
      input  inst_retired, cnt_clr, cnt_sel,
      output ret_inst, ret_pc, ret_branch, ret_taken,
      output ret_dmem_addr, ret_dmem_size, ret_bubble, ret_bp_hit,
      output cnt_rdata
   );
endinterface
`default_nettype wire

// File: rtl/ama_riscv_ret_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_ret_tracker
// Description : Shadow pipeline carrying trace payload from EXE to RET in
//               lockstep with the core, plus a bank of 8 event counters.
//               Optional macro: AMA_RISCV_RET_TRACKER_BP_EN (bp_hit tracking).
// Revision    : 1.0 - initial release
// ============================================================================
module ama_riscv_ret_tracker #(
   parameter int NSTAGES      = 3,
   parameter int BR_RES_STAGE = 0,
   parameter int CNT_W        = 32,
   parameter int CNT_SAT      = 0,
   parameter int ARCH_WIDTH   = 32
) (
   input logic                    clk,
   input logic                    rst,
   ama_riscv_ret_tracker_if.slave bus
);

   localparam int               NCNT     = 8;
   localparam logic [3:0]       SIZE_NONE = 4'd8;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef struct packed {
      logic                  valid;
      logic [31:0]           inst;
      logic [ARCH_WIDTH-1:0] pc;
      logic                  branch;
      logic                  taken;
      logic [ARCH_WIDTH-1:0] addr;
      logic [3:0]            size;
      logic                  bubble;
      logic                  bp_hit;
   } rec_t;

   rec_t             entry;
   rec_t             flush_rec;
   rec_t             bubble_rec;
   rec_t             ld  [NSTAGES];
   rec_t             stg [NSTAGES];
   rec_t             ret_q;
   logic             retire;
   logic [NCNT-1:0]  ev;
   logic [CNT_W-1:0] cnt [NCNT];

   // ---------------------------------------------------------------- entry
   always_comb begin
      entry        = '0;
      entry.valid  = bus.in_valid;
      entry.inst   = bus.in_inst;
      entry.pc     = bus.in_pc;
      entry.branch = bus.in_branch;
      entry.addr   = bus.in_dmem_valid ? bus.in_dmem_addr : '0;
      entry.size   = bus.in_dmem_valid ? {1'b0, bus.in_dmem_size} : SIZE_NONE;
`ifdef AMA_RISCV_RET_TRACKER_BP_EN
      entry.bp_hit = bus.in_branch & bus.bp_hit;
`else
      entry.bp_hit = 1'b0;
`endif
   end

   always_comb begin
      flush_rec         = '0;
      flush_rec.size    = SIZE_NONE;
      bubble_rec        = flush_rec;
      bubble_rec.bubble = 1'b1;
   end

   // ------------------------------------------------------- stage sources
   // Branch outcome is captured only by the resolving stage; all others copy.
   always_comb begin
      ld[0] = entry;
      for (int i = 1; i < NSTAGES; i++) begin
         ld[i] = stg[i-1];
      end
      for (int i = 0; i < NSTAGES; i++) begin
         if (i == BR_RES_STAGE) begin
            ld[i].taken = bus.in_br_taken & ld[i].branch;
         end
      end
   end

   // --------------------------------------------------------- stage regs
   always_ff @(posedge clk) begin
      for (int i = 0; i < NSTAGES; i++) begin
         if (rst) begin
            stg[i] <= flush_rec;
         end else if (bus.stage_en[i]) begin
            if (bus.stage_flush[i]) begin
               stg[i] <= flush_rec;
            end else if (bus.stage_bubble[i]) begin
               stg[i] <= bubble_rec;
            end else begin
               stg[i] <= ld[i];
            end
         end
      end
   end

   assign ret_q = stg[NSTAGES-1];

   // ----------------------------------------------------------- RET view
   assign bus.ret_inst      = ret_q.inst & {32{bus.inst_retired}};
   assign bus.ret_pc        = ret_q.pc & {ARCH_WIDTH{bus.inst_retired}};
   assign bus.ret_branch    = ret_q.branch;
   assign bus.ret_taken     = ret_q.taken;
   assign bus.ret_dmem_addr = ret_q.addr;
   assign bus.ret_dmem_size = ret_q.size;
   assign bus.ret_bubble    = ret_q.bubble;
   assign bus.ret_bp_hit    = ret_q.bp_hit;

   // -------------------------------------------------------------- events
   assign retire = bus.inst_retired & ret_q.valid;

   always_comb begin
      ev    = '0;
      ev[0] = 1'b1;
      ev[1] = retire;
      ev[2] = retire & ret_q.branch;
      ev[3] = retire & ret_q.branch & ret_q.taken;
      ev[4] = retire & (ret_q.size[3:2] == 2'b00);
      ev[5] = retire & (ret_q.size[3:2] == 2'b01);
      ev[6] = ~bus.inst_retired & ret_q.bubble;
      ev[7] = retire & ret_q.branch & ret_q.bp_hit;
   end

   // ------------------------------------------------------------ counters
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCNT; i++) begin
         if (rst || bus.cnt_clr) begin
            cnt[i] <= '0;
         end else if (ev[i]) begin
            if ((CNT_SAT != 0) && (cnt[i] == CNT_MAX)) begin
               cnt[i] <= cnt[i];
            end else begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
      end
   end

   assign bus.cnt_rdata = cnt[bus.cnt_sel];

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_ret_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ama_riscv_ret_tracker
// Description : Directed self-checking bench; a wrapping and a saturating
//               instance (NSTAGES=3, BR_RES_STAGE=1, CNT_W=4) see identical
//               stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_ret_tracker;

   localparam int NS = 3;
   localparam int AW = 32;
   localparam int CW = 4;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   ama_riscv_ret_tracker_if #(.NSTAGES(NS), .ARCH_WIDTH(AW), .CNT_W(CW)) ifa ();
   ama_riscv_ret_tracker_if #(.NSTAGES(NS), .ARCH_WIDTH(AW), .CNT_W(CW)) ifb ();

   ama_riscv_ret_tracker #(
      .NSTAGES(NS), .BR_RES_STAGE(1), .CNT_W(CW), .CNT_SAT(0), .ARCH_WIDTH(AW)
   ) u_wrap (.clk(clk), .rst(rst), .bus(ifa));

   ama_riscv_ret_tracker #(
      .NSTAGES(NS), .BR_RES_STAGE(1), .CNT_W(CW), .CNT_SAT(1), .ARCH_WIDTH(AW)
   ) u_sat (.clk(clk), .rst(rst), .bus(ifb));

   assign ifb.stage_en      = ifa.stage_en;
   assign ifb.stage_flush   = ifa.stage_flush;
   assign ifb.stage_bubble  = ifa.stage_bubble;
   assign ifb.in_valid      = ifa.in_valid;
   assign ifb.in_inst       = ifa.in_inst;
   assign ifb.in_pc         = ifa.in_pc;
   assign ifb.in_branch     = ifa.in_branch;
   assign ifb.in_dmem_addr  = ifa.in_dmem_addr;
   assign ifb.in_dmem_valid = ifa.in_dmem_valid;
   assign ifb.in_dmem_size  = ifa.in_dmem_size;
   assign ifb.in_br_taken   = ifa.in_br_taken;
`ifdef AMA_RISCV_RET_TRACKER_BP_EN
   assign ifb.bp_hit        = ifa.bp_hit;
`endif
   assign ifb.inst_retired  = ifa.inst_retired;
   assign ifb.cnt_clr       = ifa.cnt_clr;
   assign ifb.cnt_sel       = ifa.cnt_sel;

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [2:0] sel,
                          input logic [CW-1:0] exp_wrap, input logic [CW-1:0] exp_sat);
      ifa.cnt_sel = sel;
      #1;
      chk({tag, "_wrap"}, ifa.cnt_rdata, exp_wrap);
      chk({tag, "_sat"},  ifb.cnt_rdata, exp_sat);
   endtask

   task automatic entry(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic br, input logic [31:0] addr, input logic dv,
                        input logic [2:0] sz);
      ifa.in_valid      = v;
      ifa.in_inst       = inst;
      ifa.in_pc         = pc;
      ifa.in_branch     = br;
      ifa.in_dmem_addr  = addr;
      ifa.in_dmem_valid = dv;
      ifa.in_dmem_size  = sz;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst              = 1'b1;
      ifa.stage_en     = '1;
      ifa.stage_flush  = '0;
      ifa.stage_bubble = '0;
      ifa.in_br_taken  = 1'b0;
`ifdef AMA_RISCV_RET_TRACKER_BP_EN
      ifa.bp_hit       = 1'b0;
`endif
      ifa.inst_retired = 1'b0;
      ifa.cnt_clr      = 1'b0;
      ifa.cnt_sel      = 3'd0;
      entry(0, 0, 0, 0, 0, 0, 0);

      // reset then 10 idle cycles
      step();
      step();
      rst = 1'b0;
      repeat (10) step();
      chk("rst_inst",   ifa.ret_inst, 0);
      chk("rst_pc",     ifa.ret_pc, 0);
      chk("rst_branch", ifa.ret_branch, 0);
      chk("rst_taken",  ifa.ret_taken, 0);
      chk("rst_addr",   ifa.ret_dmem_addr, 0);
      chk("rst_size",   ifa.ret_dmem_size, 8);
      chk("rst_bubble", ifa.ret_bubble, 0);
      chk("rst_bphit",  ifa.ret_bp_hit, 0);
      chk_cnt("rst_cycles", 3'd0, 4'd10, 4'd10);
      for (int s = 1; s < 8; s++) chk_cnt("rst_cnt", 3'(s), 4'd0, 4'd0);

      // lw then sw through the pipe
      entry(1, 32'h0020a083, 32'h100, 0, 32'h2000, 1, 3'd2);
      step();
      entry(1, 32'h0020a223, 32'h104, 0, 32'h2004, 1, 3'd6);
      step();
      entry(0, 0, 0, 0, 0, 0, 0);
      step();
      chk("lw_pc_masked", ifa.ret_pc, 0);
      ifa.inst_retired = 1'b1;
      #1;
      chk("lw_pc",   ifa.ret_pc, 32'h100);
      chk("lw_inst", ifa.ret_inst, 32'h0020a083);
      chk("lw_addr", ifa.ret_dmem_addr, 32'h2000);
      chk("lw_size", ifa.ret_dmem_size, 2);
      step();
      chk("sw_pc",   ifa.ret_pc, 32'h104);
      chk("sw_size", ifa.ret_dmem_size, 6);
      step();
      ifa.inst_retired = 1'b0;
      chk_cnt("loads",   3'd4, 4'd1, 4'd1);
      chk_cnt("stores",  3'd5, 4'd1, 4'd1);
      chk_cnt("retired", 3'd1, 4'd2, 4'd2);

      // branch resolved while its record loads stage 1
      entry(1, 32'h00000463, 32'h40, 1, 32'hdead, 0, 3'd0);
      step();
      entry(0, 0, 0, 0, 0, 0, 0);
      ifa.in_br_taken = 1'b1;
      step();
      ifa.in_br_taken = 1'b0;
      step();
      ifa.inst_retired = 1'b1;
      #1;
      chk("br_pc",     ifa.ret_pc, 32'h40);
      chk("br_branch", ifa.ret_branch, 1);
      chk("br_taken",  ifa.ret_taken, 1);
      chk("br_addr",   ifa.ret_dmem_addr, 0);
      chk("br_size",   ifa.ret_dmem_size, 8);
      step();
      ifa.inst_retired = 1'b0;
      chk_cnt("branches", 3'd2, 4'd1, 4'd1);
      chk_cnt("takens",   3'd3, 4'd1, 4'd1);

      // same branch, resolution pulse one cycle late
      entry(1, 32'h00000463, 32'h44, 1, 0, 0, 3'd0);
      step();
      entry(0, 0, 0, 0, 0, 0, 0);
      step();
      ifa.in_br_taken = 1'b1;
      step();
      ifa.in_br_taken = 1'b0;
      ifa.inst_retired = 1'b1;
      #1;
      chk("late_branch", ifa.ret_branch, 1);
      chk("late_taken",  ifa.ret_taken, 0);
      step();
      ifa.inst_retired = 1'b0;
      chk_cnt("branches2", 3'd2, 4'd2, 4'd2);
      chk_cnt("takens2",   3'd3, 4'd1, 4'd1);

      // stage 1 stalled while stage 2 takes bubbles
      entry(1, 32'h00000013, 32'h80, 0, 0, 0, 3'd0);
      step();
      entry(0, 0, 0, 0, 0, 0, 0);
      step();
      ifa.stage_en     = 3'b101;
      ifa.stage_bubble = 3'b100;
      step();
      chk("bub_ret1", ifa.ret_bubble, 1);
      step();
      chk("bub_ret2", ifa.ret_bubble, 1);
      ifa.stage_en     = 3'b111;
      ifa.stage_bubble = 3'b000;
      step();
      chk("held_bubble", ifa.ret_bubble, 0);
      ifa.inst_retired = 1'b1;
      #1;
      chk("held_pc", ifa.ret_pc, 32'h80);
      step();
      ifa.inst_retired = 1'b0;
      chk_cnt("bubble_cnt", 3'd6, 4'd2, 4'd2);
      chk_cnt("retired2",   3'd1, 4'd5, 4'd5);

      // flush and bubble together on stage 0: flush wins
      entry(1, 32'hdeadbeef, 32'h200, 1, 32'h3000, 1, 3'd2);
      ifa.stage_flush  = 3'b001;
      ifa.stage_bubble = 3'b001;
      step();
      ifa.stage_flush  = 3'b000;
      ifa.stage_bubble = 3'b000;
      entry(0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      ifa.inst_retired = 1'b1;
      #1;
      chk("fl_bubble", ifa.ret_bubble, 0);
      chk("fl_inst",   ifa.ret_inst, 0);
      chk("fl_pc",     ifa.ret_pc, 0);
      chk("fl_branch", ifa.ret_branch, 0);
      chk("fl_addr",   ifa.ret_dmem_addr, 0);
      chk("fl_size",   ifa.ret_dmem_size, 8);
      ifa.inst_retired = 1'b0;

      // counter clear, then 17 retirements: wrap vs saturate
      ifa.cnt_clr = 1'b1;
      step();
      ifa.cnt_clr = 1'b0;
      chk_cnt("clr_retired", 3'd1, 4'd0, 4'd0);
      chk_cnt("clr_bubble",  3'd6, 4'd0, 4'd0);
      entry(1, 32'h00000013, 32'h300, 0, 0, 0, 3'd0);
      step();
      step();
      step();
      ifa.inst_retired = 1'b1;
      repeat (17) step();
      ifa.inst_retired = 1'b0;
      entry(0, 0, 0, 0, 0, 0, 0);
      chk_cnt("ovf_retired", 3'd1, 4'd1, 4'd15);

      // clear beats a simultaneous retirement
      ifa.inst_retired = 1'b1;
      ifa.cnt_clr      = 1'b1;
      step();
      ifa.inst_retired = 1'b0;
      ifa.cnt_clr      = 1'b0;
      chk_cnt("clr_vs_ret", 3'd1, 4'd0, 4'd0);

      // reset mid-flight discards the in-flight record
      entry(1, 32'h00000013, 32'h500, 0, 0, 0, 3'd0);
      step();
      entry(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      step();
      ifa.inst_retired = 1'b1;
      #1;
      chk("midrst_pc", ifa.ret_pc, 0);
      ifa.inst_retired = 1'b0;
      chk_cnt("midrst_bp", 3'd7, 4'd0, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
